// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, deframes 11-bit frames and
// folds E0/F0 prefixes into a toggle-flagged key event word.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 12000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic             clk_filt_q, clk_filt_d, clk_filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic [10:0]      key_q, key_d;
  logic             err_q, err_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // The filtered clock follows the synchronized clock only after a run of FILTER_LEN differing
  // samples; any agreeing sample restarts the run.
  always_comb begin
    filt_cnt_d = '0;
    clk_filt_d = clk_filt_q;
    if (clk_sync_q != clk_filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_filt_q      <= clk_filt_d;
      clk_filt_prev_q <= clk_filt_q;
      filt_cnt_q      <= filt_cnt_d;
    end
  end

  assign fall = clk_filt_prev_q & ~clk_filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    err_d     = 1'b0;
    tmo_cnt_d = '0;

    // Abort a stalled frame; a falling edge restarts the watchdog.
    if (state_q != StIdle && !fall) begin
      if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
        state_d = StIdle;
        err_d   = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end

    if (fall) begin
      case (state_q)
        StIdle: begin
          if (!data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = data_sync_q;
          state_d  = StStop;
        end
        StStop: begin
          state_d   = StIdle;
          bit_cnt_d = 3'd0;
          if (!data_sync_q || !(^{shift_q, parity_q})) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            case (shift_q)
              8'hE0: ext_d = 1'b1;
              8'hF0: brk_d = 1'b1;
              8'hE1: ;
              8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
              default: begin
                key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
            endcase
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      key_q     <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      key_q     <= key_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder: drives PS/2 frames bit by bit and checks key events and
// error pulses against a byte-level model of the decoding rules.
module tb_ps2_key_decoder;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 400;
  localparam int          HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_decoder #(
    .FILTER_LEN(FILT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  // Observation state
  int          cyc = 0;
  int          err_pulses = 0;
  int          err_cycles = 0;
  int          key_updates = 0;
  int          chg_cyc = 0;
  logic        err_prev = 1'b0;
  logic [10:0] key_prev = '0;

  // Reference model state
  logic [10:0] exp_key = '0;
  logic        m_ext = 1'b0;
  logic        m_brk = 1'b0;
  int          exp_errs = 0;
  int          exp_updates = 0;
  int          stop_cyc = 0;
  int          fall_cyc = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      key_prev = ps2_key;
      err_prev = 1'b0;
    end else begin
      if (frame_err) err_cycles++;
      if (frame_err && !err_prev) err_pulses++;
      err_prev = frame_err;
      if (ps2_key != key_prev) begin
        key_updates++;
        chg_cyc = cyc;
      end
      key_prev = ps2_key;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns 1 when the byte produces a key event.
  function automatic bit model_byte(input logic [7:0] b, input bit good);
    bit upd = 1'b0;
    if (!good) begin
      exp_errs++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      upd = 1'b0;
    end else if (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      exp_key = {~exp_key[10], ~m_brk, m_ext, b};
      exp_updates++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      upd = 1'b1;
    end
    return upd;
  endfunction

  task automatic drive_bit(input logic d, input bit glitch);
    @(negedge clk_sys);
    ps2_data = d;
    repeat (HALF) @(negedge clk_sys);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FILT - 2) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk_sys);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input logic stop, input int nbits,
                            input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ ~par_ok, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], i == glitch_bit);
    stop_cyc = fall_cyc;
    @(negedge clk_sys);
    ps2_data = 1'b1;
  endtask

  task automatic after_frame(input string tag, input bit upd);
    int d;
    repeat (30) @(negedge clk_sys);
    check_val({tag, "_key"}, 32'(ps2_key), 32'(exp_key));
    check_val({tag, "_errs"}, 32'(err_pulses), 32'(exp_errs));
    check_val({tag, "_err_width"}, 32'(err_cycles), 32'(err_pulses));
    check_val({tag, "_updates"}, 32'(key_updates), 32'(exp_updates));
    if (upd) begin
      d = chg_cyc - stop_cyc;
      check_val({tag, "_latency_ok"}, 32'(d >= FILT + 1 && d <= FILT + 6), 32'd1);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit par_ok, input logic stop,
                       input int glitch_bit);
    bit upd;
    send_frame(b, par_ok, stop, 11, glitch_bit);
    upd = model_byte(b, par_ok && stop);
    after_frame(tag, upd);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check_val({tag, "_rst_key"}, 32'(ps2_key), 32'd0);
    check_val({tag, "_rst_err"}, 32'(frame_err), 32'd0);
    exp_key = '0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  logic [7:0] specials [8] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFA, 8'hFE, 8'hFF};

  initial begin
    repeat (5) @(negedge clk_sys);
    check_val("init_key", 32'(ps2_key), 32'd0);
    check_val("init_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);

    frame("make29", 8'h29, 1'b1, 1'b1, -1);
    check_val("make29_abs", 32'(ps2_key), 32'h629);
    frame("brk_f0", 8'hF0, 1'b1, 1'b1, -1);
    frame("brk29", 8'h29, 1'b1, 1'b1, -1);
    check_val("brk29_abs", 32'(ps2_key), 32'h029);

    do_reset("r1");
    frame("ext_e0", 8'hE0, 1'b1, 1'b1, -1);
    frame("ext75", 8'h75, 1'b1, 1'b1, -1);
    check_val("ext75_abs", 32'(ps2_key), 32'h775);
    frame("plain16", 8'h16, 1'b1, 1'b1, -1);
    check_val("plain16_abs", 32'(ps2_key), 32'h216);

    frame("bad_par", 8'h29, 1'b0, 1'b1, -1);
    frame("after_bad", 8'h1C, 1'b1, 1'b1, -1);
    check_val("after_bad_abs", 32'(ps2_key[9:0]), 32'h21C);
    frame("bad_stop", 8'h3A, 1'b1, 1'b0, -1);

    // Partial frame then silence: watchdog must abort it.
    send_frame(8'h16, 1'b1, 1'b1, 4, -1);
    repeat (TMO + 10) @(negedge clk_sys);
    exp_errs++;
    after_frame("timeout", 1'b0);
    frame("post_tmo16", 8'h16, 1'b1, 1'b1, -1);
    frame("glitch16", 8'h16, 1'b1, 1'b1, 5);

    // Reset during data bit 4.
    send_frame(8'h05, 1'b1, 1'b1, 5, -1);
    @(negedge clk_sys);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk_sys);
    do_reset("r2");
    frame("post_rst05", 8'h05, 1'b1, 1'b1, -1);
    check_val("post_rst05_abs", 32'(ps2_key), 32'h605);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit par_ok;
      logic stop;
      int gb;
      if ($urandom_range(0, 9) < 3) b = specials[$urandom_range(0, 7)];
      else b = 8'($urandom_range(0, 255));
      par_ok = ($urandom_range(0, 9) != 0);
      stop   = ($urandom_range(0, 11) != 0);
      gb     = int'($urandom_range(0, 21));
      frame($sformatf("rnd%0d_%02h", i, b), b, par_ok, stop, gb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
